matmul_engine: RTL and testbench

Parametrised N×N signed matrix multiplier, successor to the fixed 10×10 top-level multiplier. It owns the A, B and C storage and is loaded through a write port. A single sequential multiply-accumulate datapath computes C = A·B, or C += A·B in accumulate mode. Each element is streamed out as it completes, and the full result stays readable through a registered read port.

---
 rtl/matmul_engine.sv | 155 +++++++++++++++
 tb/tb_matmul_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_engine.sv
// matmul_engine: parametrised N x N signed matrix multiplier.
// A and B are loaded through a write port; one sequential MAC computes
// C = A*B (or C += A*B) in row-major order, streaming each finished element
// out and keeping the full result readable through a registered read port.
module matmul_engine #(
  parameter int N  = 10,
  parameter int DW = 8,
  parameter int AW = 2*DW+4,
  parameter int IW = $clog2(N*N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  load_sel,
  input  logic [IW-1:0]         load_addr,
  input  logic [DW-1:0]         load_data,
  input  logic                  start,
  input  logic                  acc_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  res_valid,
  output logic [$clog2(N)-1:0]  res_row,
  output logic [$clog2(N)-1:0]  res_col,
  output logic [AW-1:0]         res_data,
  input  logic [IW-1:0]         rd_addr,
  output logic [AW-1:0]         rd_data
);

  localparam int RW = $clog2(N);
  localparam int NN = N*N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  // Element storage, flat row-major (index = row*N + col)
  logic [DW-1:0] a_mem [NN];
  logic [DW-1:0] b_mem [NN];
  logic [AW-1:0] c_mem [NN];

  logic [1:0]    state_reg;
  logic [RW-1:0] i_reg, j_reg, k_reg;
  logic          mode_reg;
  logic [AW-1:0] acc_reg;
  logic          done_reg, res_valid_reg;
  logic [RW-1:0] res_row_reg, res_col_reg;
  logic [AW-1:0] res_data_reg, rd_data_reg;

  logic [IW-1:0]          a_idx, b_idx, c_idx;
  logic signed [2*DW-1:0] prod;
  logic [AW-1:0]          prod_ext, base, acc_next;
  logic                   load_ok, rd_ok;

  // Out-of-range flat indices exist whenever N*N is not a power of two
  assign load_ok = load_en && (state_reg == S_IDLE) &&
                   ({1'b0, load_addr} < (IW+1)'(NN));
  assign rd_ok   = {1'b0, rd_addr} < (IW+1)'(NN);

  // MAC datapath: the first term of each element starts from 0 or the old C
  always_comb begin
    a_idx    = IW'(i_reg) * IW'(N) + IW'(k_reg);
    b_idx    = IW'(k_reg) * IW'(N) + IW'(j_reg);
    c_idx    = IW'(i_reg) * IW'(N) + IW'(j_reg);
    prod     = $signed(a_mem[a_idx]) * $signed(b_mem[b_idx]);
    prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
    base     = mode_reg ? c_mem[c_idx] : '0;
    acc_next = ((k_reg == '0) ? base : acc_reg) + prod_ext;
  end

  // A/B write port; operands are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (load_ok) begin
      if (load_sel) b_mem[load_addr] <= load_data;
      else          a_mem[load_addr] <= load_data;
    end
  end

  // Control FSM, accumulator, result stream and C write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      mode_reg      <= 1'b0;
      acc_reg       <= '0;
      done_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      res_row_reg   <= '0;
      res_col_reg   <= '0;
      res_data_reg  <= '0;
      for (int n = 0; n < NN; n++) c_mem[n] <= '0;
    end else begin
      done_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_MAC;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            mode_reg  <= acc_mode;
          end
        end
        S_MAC: begin
          acc_reg <= acc_next;
          if (k_reg == RW'(N-1)) begin
            k_reg     <= '0;
            state_reg <= S_WRITE;
          end else begin
            k_reg <= k_reg + RW'(1);
          end
        end
        S_WRITE: begin
          c_mem[c_idx]  <= acc_reg;
          res_valid_reg <= 1'b1;
          res_row_reg   <= i_reg;
          res_col_reg   <= j_reg;
          res_data_reg  <= acc_reg;
          state_reg     <= S_MAC;
          if (j_reg == RW'(N-1)) begin
            j_reg <= '0;
            if (i_reg == RW'(N-1)) begin
              i_reg     <= '0;
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              i_reg <= i_reg + RW'(1);
            end
          end else begin
            j_reg <= j_reg + RW'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Registered C read port, usable at any time
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data_reg <= '0;
    else if (rd_ok) rd_data_reg <= c_mem[rd_addr];
    else            rd_data_reg <= '0;
  end

  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign res_valid = res_valid_reg;
  assign res_row   = res_row_reg;
  assign res_col   = res_col_reg;
  assign res_data  = res_data_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: randomized and directed runs of matmul_engine checked
// against a plain-arithmetic matrix model (N=10, DW=8, AW=20).
module tb_matmul_engine;

  localparam int N  = 10;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int IW = 7;
  localparam int RW = 4;
  localparam int NN = N*N;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en, load_sel, start, acc_mode;
  logic [IW-1:0] load_addr, rd_addr;
  logic [DW-1:0] load_data;
  logic          busy, done, res_valid;
  logic [RW-1:0] res_row, res_col;
  logic [AW-1:0] res_data, rd_data;

  matmul_engine #(.N(N), .DW(DW), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .start(start), .acc_mode(acc_mode),
    .busy(busy), .done(done), .res_valid(res_valid),
    .res_row(res_row), .res_col(res_col), .res_data(res_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int     vec_cnt = 0;
  int     err_cnt = 0;
  longint ma [NN];
  longint mb [NN];
  longint mc [NN];
  longint ex [NN];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    longint r;
    r = v & ((64'sd1 <<< AW) - 1);
    if (r >= (64'sd1 <<< (AW-1))) r = r - (64'sd1 <<< AW);
    return r;
  endfunction

  function automatic longint sx(input logic [AW-1:0] v);
    return longint'($signed(v));
  endfunction

  // One write; called at a falling edge, returns at the next falling edge
  task automatic load_one(input bit sel, input int addr, input int val);
    load_en   = 1'b1;
    load_sel  = sel;
    load_addr = IW'(addr);
    load_data = DW'(val);
    if (addr < NN) begin
      if (sel) mb[addr] = val;
      else     ma[addr] = val;
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // kind 0: A=k,B=j  1: A=I,B=10k+j-50  2: all -128  3: random
  task automatic fill(input int kind);
    int va, vb;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (kind)
          0: begin va = c; vb = c; end
          1: begin va = (r == c) ? 1 : 0; vb = r*10 + c - 50; end
          2: begin va = -128; vb = -128; end
          default: begin
            va = int'($urandom_range(0, 255)) - 128;
            vb = int'($urandom_range(0, 255)) - 128;
          end
        endcase
        load_one(1'b0, r*N + c, va);
        load_one(1'b1, r*N + c, vb);
      end
  endtask

  // Reference result: C = A*B (+ old C) with wrap to AW bits
  task automatic model(input bit mode);
    longint s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = mode ? mc[r*N + c] : 0;
        for (int k = 0; k < N; k++) s += ma[r*N + k] * mb[k*N + c];
        ex[r*N + c] = wrap(s);
      end
  endtask

  task automatic run(input bit mode, input bit disturb, input bit co_load,
                     input bit hold, input string name);
    int     cnt, e, v;
    bit     seen_done;
    longint old_last;
    rd_addr = IW'(NN-1);
    if (co_load) begin
      v = int'($urandom_range(0, 255)) - 128;
      load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = DW'(v);
      ma[0] = v;
    end
    start = 1'b1;
    acc_mode = mode;
    @(negedge clk);
    start = hold;
    load_en = 1'b0;
    model(mode);
    old_last = mc[NN-1];
    check_eq({name, " busy_after_start"}, longint'(busy), 1);
    cnt = 0; e = 0; seen_done = 1'b0;
    while (!seen_done && cnt < NN*(N+1) + 20) begin
      @(negedge clk);
      cnt++;
      if (disturb && cnt == 300) begin
        start = 1'b1; load_en = 1'b1; load_sel = 1'($urandom);
        load_addr = IW'($urandom_range(0, NN-1)); load_data = DW'($urandom);
      end else if (disturb && cnt == 301) begin
        start = hold; load_en = 1'b0;
      end
      if (cnt == 500) check_eq({name, " rd_old_mid_run"}, sx(rd_data), old_last);
      if (res_valid) begin
        if (e < NN) begin
          check_eq({name, " row"}, longint'(res_row), e / N);
          check_eq({name, " col"}, longint'(res_col), e % N);
          check_eq({name, " data"}, sx(res_data), ex[e]);
          check_eq({name, " timing"}, cnt, (e+1)*(N+1));
        end
        e++;
      end
      if (done) begin
        seen_done = 1'b1;
        check_eq({name, " busy_at_done"}, longint'(busy), 0);
        check_eq({name, " last_valid_with_done"}, longint'(res_valid), 1);
      end
    end
    check_eq({name, " done_seen"}, longint'(seen_done), 1);
    check_eq({name, " done_cycle"}, cnt, NN*(N+1));
    check_eq({name, " element_count"}, e, NN);
    for (int n = 0; n < NN; n++) mc[n] = ex[n];
    @(negedge clk);
    check_eq({name, " rd_latency"}, sx(rd_data), ex[NN-1]);
    check_eq({name, " done_pulse"}, longint'(done), 0);
    if (hold) begin
      check_eq({name, " restart_busy"}, longint'(busy), 1);
      start = 1'b0;
    end
    $display("run %s mode=%0d: %0d elements, done after %0d cycles, C[99]=%0d",
             name, mode, e, cnt, ex[NN-1]);
  endtask

  task automatic readback(input string name);
    for (int a = 0; a < NN; a++) begin
      rd_addr = IW'(a);
      @(negedge clk);
      check_eq({name, " readback"}, sx(rd_data), mc[a]);
    end
  endtask

  task automatic rd_const(input int addr, input longint exp, input string tag);
    rd_addr = IW'(addr);
    @(negedge clk);
    check_eq(tag, sx(rd_data), exp);
  endtask

  // Reset in the middle of a running job once 40 elements have been produced
  task automatic mid_reset();
    int pulses, cyc;
    pulses = 0; cyc = 0;
    while (pulses < 40 && cyc < 40*(N+1) + 20) begin
      @(negedge clk);
      cyc++;
      if (res_valid) pulses++;
    end
    check_eq("mid_reset reached_element_40", pulses, 40);
    rst = 1'b1;
    #1;
    check_eq("mid_reset busy", longint'(busy), 0);
    check_eq("mid_reset done", longint'(done), 0);
    check_eq("mid_reset res_valid", longint'(res_valid), 0);
    check_eq("mid_reset res_row", longint'(res_row), 0);
    check_eq("mid_reset res_col", longint'(res_col), 0);
    check_eq("mid_reset res_data", sx(res_data), 0);
    check_eq("mid_reset rd_data", sx(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < NN; n++) mc[n] = 0;
    $display("reset applied after %0d elements", pulses);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; acc_mode = 1'b0; rd_addr = '0;
    for (int n = 0; n < NN; n++) begin ma[n] = 0; mb[n] = 0; mc[n] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset busy", longint'(busy), 0);
    check_eq("reset done", longint'(done), 0);
    check_eq("reset res_valid", longint'(res_valid), 0);
    check_eq("reset res_row", longint'(res_row), 0);
    check_eq("reset res_col", longint'(res_col), 0);
    check_eq("reset res_data", sx(res_data), 0);
    check_eq("reset rd_data", sx(rd_data), 0);

    fill(0);
    run(1'b0, 1'b0, 1'b0, 1'b0, "ramp");
    rd_const(37, 315, "ramp C[3][7]");
    readback("ramp");

    load_one(1'b0, 100, 55);
    load_one(1'b1, 127, -3);
    run(1'b1, 1'b1, 1'b0, 1'b0, "ramp_acc");
    rd_const(37, 630, "ramp_acc C[3][7]");
    readback("ramp_acc");

    fill(1);
    run(1'b0, 1'b0, 1'b0, 1'b0, "identity");
    rd_const(0, -50, "identity C[0][0]");
    readback("identity");

    fill(2);
    run(1'b0, 1'b0, 1'b0, 1'b0, "min");
    rd_const(55, 163840, "min C[5][5]");
    run(1'b1, 1'b0, 1'b0, 1'b0, "min_acc2");
    run(1'b1, 1'b0, 1'b0, 1'b0, "min_acc3");
    run(1'b1, 1'b0, 1'b0, 1'b0, "min_acc4_wrap");
    readback("min_wrap");

    fill(3);
    run(1'b0, 1'b0, 1'b1, 1'b0, "rand");
    readback("rand");
    run(1'b1, 1'b1, 1'b0, 1'b1, "rand_acc_hold");
    mid_reset();
    readback("after_reset");
    run(1'b0, 1'b0, 1'b0, 1'b0, "rand_rerun");
    readback("rand_rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
